// File: rtl/score_pkg.sv
// Shared types and constants for the score/lives register bank feeding the scoreboard.
package score_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [1:0] ST_OVER  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [3:0] MAX_LIVES       = 4'd9;
  localparam bcd_t       MAX_SCORE_ONES  = 4'd9;
  localparam bcd_t       MAX_SCORE_TENS  = 4'd9;
  localparam bcd_t       EXTRA_LIFE_TENS = 4'd5;

endpackage

// File: rtl/score_keeper_bcd_pair_incr.sv
// Two-digit BCD incrementer; holds the value and flags saturation at 99.
module bcd_pair_incr
  import score_pkg::*;
(
  input  bcd_t ones,
  input  bcd_t tens,
  output bcd_t ones_inc,
  output bcd_t tens_inc,
  output logic saturated
);

  always_comb begin
    saturated = (ones == MAX_SCORE_ONES) && (tens == MAX_SCORE_TENS);
    ones_inc  = ones;
    tens_inc  = tens;
    if (!saturated) begin
      if (ones == 4'd9) begin
        ones_inc = 4'd0;
        tens_inc = tens + 4'd1;
      end else begin
        ones_inc = ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score/lives bank: buffers point and life-loss pulses, commits them at the vsync rising edge.
// Optional SCORE_EXTRA_LIFE_EN awards one extra life per game when the score crosses 49->50.
//
// state | meaning
// OVER  | attract mode, events ignored, game_over high
// PLAY  | collecting events, waiting for a frame edge
// DRAIN | committing pending points one per cycle, then pending losses
module score_keeper
  import score_pkg::*;
#(
  parameter int START_LIVES = 3,
  parameter int PEND_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       point,
  input  logic       lose_life,
  input  logic       new_game,
  output bcd_t       score0,
  output bcd_t       score1,
  output logic [3:0] lives,
  output logic       game_over
);

  localparam int              CW         = (PEND_W > 4) ? PEND_W : 4;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [3:0]      START_L    = 4'(START_LIVES);

  logic [1:0]        state, state_nxt;
  logic              vsync_q, frame_edge;
  logic [PEND_W-1:0] pend_pts, pend_pts_nxt;
  logic [PEND_W-1:0] pend_loss, pend_loss_nxt;
  bcd_t              score0_nxt, score1_nxt;
  bcd_t              inc_ones, inc_tens;
  logic              inc_sat;
  logic [3:0]        lives_nxt;
  logic [CW-1:0]     loss_c, lives_c;
  logic              capture;
`ifdef SCORE_EXTRA_LIFE_EN
  logic              bonus_done, bonus_nxt;
`endif

  bcd_pair_incr u_incr (
    .ones      (score0),
    .tens      (score1),
    .ones_inc  (inc_ones),
    .tens_inc  (inc_tens),
    .saturated (inc_sat)
  );

  assign frame_edge = vsync & ~vsync_q;
  assign capture    = (state != ST_OVER);
  assign loss_c     = CW'(pend_loss);
  assign lives_c    = CW'(lives);

  always_comb begin
    state_nxt     = state;
    score0_nxt    = score0;
    score1_nxt    = score1;
    lives_nxt     = lives;
    pend_pts_nxt  = pend_pts;
    pend_loss_nxt = pend_loss;
`ifdef SCORE_EXTRA_LIFE_EN
    bonus_nxt     = bonus_done;
`endif

    if (capture && point && (pend_pts != PEND_MAX))
      pend_pts_nxt = pend_pts + 1'b1;
    if (capture && lose_life && (pend_loss != PEND_MAX))
      pend_loss_nxt = pend_loss + 1'b1;

    case (state)
      ST_PLAY: begin
        if (frame_edge)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pend_pts != '0) begin
          // a point arriving in the same cycle cancels the decrement
          pend_pts_nxt = point ? pend_pts : pend_pts - 1'b1;
          if (!inc_sat) begin
            score0_nxt = inc_ones;
            score1_nxt = inc_tens;
          end
`ifdef SCORE_EXTRA_LIFE_EN
          if (!inc_sat && !bonus_done && (score0 == 4'd9) &&
              (score1 == EXTRA_LIFE_TENS - 4'd1)) begin
            bonus_nxt = 1'b1;
            if (lives < MAX_LIVES)
              lives_nxt = lives + 4'd1;
          end
`endif
        end else begin
          lives_nxt     = (loss_c >= lives_c) ? 4'd0 : 4'(lives_c - loss_c);
          pend_loss_nxt = PEND_W'(lose_life);
          state_nxt     = (lives_nxt == 4'd0) ? ST_OVER : ST_PLAY;
        end
      end
      default: ;
    endcase

    if (new_game) begin
      state_nxt     = ST_PLAY;
      score0_nxt    = 4'd0;
      score1_nxt    = 4'd0;
      lives_nxt     = START_L;
      pend_pts_nxt  = '0;
      pend_loss_nxt = '0;
`ifdef SCORE_EXTRA_LIFE_EN
      bonus_nxt     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_OVER;
      vsync_q   <= 1'b0;
      score0    <= 4'd0;
      score1    <= 4'd0;
      lives     <= 4'd0;
      game_over <= 1'b1;
      pend_pts  <= '0;
      pend_loss <= '0;
    end else begin
      state     <= state_nxt;
      vsync_q   <= vsync;
      score0    <= score0_nxt;
      score1    <= score1_nxt;
      lives     <= lives_nxt;
      game_over <= (state_nxt == ST_OVER);
      pend_pts  <= pend_pts_nxt;
      pend_loss <= pend_loss_nxt;
    end
  end

`ifdef SCORE_EXTRA_LIFE_EN
  always_ff @(posedge clk) begin
    if (reset) bonus_done <= 1'b0;
    else       bonus_done <= bonus_nxt;
  end
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus a randomized run against an integer game model.
module tb_score_keeper;

  localparam int START_LIVES = 3;
  localparam int PMAX        = 15;
  localparam int M_OVER = 0, M_PLAY = 1, M_DRAIN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, vsync = 1'b0, point = 1'b0, lose_life = 1'b0, new_game = 1'b0;
  logic [3:0] score0, score1, lives;
  logic       game_over;
  logic [12:0] obs, exp_v;

  int checks = 0;
  int errors = 0;

  int m_score, m_lives, m_pp, m_pl, m_mode;
  bit m_vsq, m_bonus;

  score_keeper #(.START_LIVES(START_LIVES), .PEND_W(4)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .point(point), .lose_life(lose_life),
    .new_game(new_game), .score0(score0), .score1(score1), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;
  assign obs = {score1, score0, lives, game_over};

  function automatic logic [12:0] model_out();
    return {4'(m_score / 10), 4'(m_score % 10), 4'(m_lives), (m_mode == M_OVER)};
  endfunction

  task automatic model_reset();
    m_score = 0; m_lives = 0; m_pp = 0; m_pl = 0; m_mode = M_OVER; m_vsq = 0; m_bonus = 0;
  endtask

  task automatic model_tick(input bit p, input bit l, input bit ng, input bit vs);
    int pp_n, pl_n;
    bit edge_seen;
    edge_seen = vs && !m_vsq;
    m_vsq = vs;
    if (ng) begin
      m_score = 0; m_lives = START_LIVES; m_pp = 0; m_pl = 0; m_mode = M_PLAY; m_bonus = 0;
      return;
    end
    pp_n = m_pp; pl_n = m_pl;
    if (m_mode != M_OVER) begin
      if (p && m_pp < PMAX) pp_n = m_pp + 1;
      if (l && m_pl < PMAX) pl_n = m_pl + 1;
    end
    if (m_mode == M_PLAY) begin
      if (edge_seen) m_mode = M_DRAIN;
    end else if (m_mode == M_DRAIN) begin
      if (m_pp > 0) begin
        pp_n = m_pp - 1 + (p ? 1 : 0);
        if (m_score < 99) begin
          m_score++;
`ifdef SCORE_EXTRA_LIFE_EN
          if (m_score == 50 && !m_bonus) begin
            m_bonus = 1;
            if (m_lives < 9) m_lives++;
          end
`endif
        end
      end else begin
        m_lives = m_lives - ((m_pl < m_lives) ? m_pl : m_lives);
        pl_n = l ? 1 : 0;
        m_mode = (m_lives == 0) ? M_OVER : M_PLAY;
      end
    end
    m_pp = pp_n; m_pl = pl_n;
  endtask

  task automatic step(input bit p, input bit l, input bit ng, input bit vs);
    @(negedge clk);
    point = p; lose_life = l; new_game = ng; vsync = vs;
    @(posedge clk);
    model_tick(p, l, ng, vs);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; point = 0; lose_life = 0; new_game = 0; vsync = 0;
    @(posedge clk);
    model_reset();
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulses(input int n, input bit p, input bit l);
    for (int i = 0; i < n; i++) step(p, l, 0, 0);
  endtask

  task automatic frame();
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    exp_v = {8'h00, 4'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, exp_v);
    end
    frame();
    pulses(3, 1, 0);
    frame();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL over_ignores_points: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_commit_on_frame();
    step(0, 0, 1, 0);
    pulses(3, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    exp_v = {8'h00, 4'd3, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL hold_until_vsync: got %h expected %h", obs, exp_v);
    end
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL drain_cycle%0d: got %h expected %h", i, obs, model_out());
      end
    end
    exp_v = {8'h03, 4'd3, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL score_03: got %h expected %h", obs, exp_v);
    end
    frame();
  endtask

  task automatic test_carry_saturation();
    int rem, n;
    step(0, 0, 1, 0);
    pulses(8, 1, 0); frame();
    pulses(4, 1, 0); frame();
    exp_v = {8'h12, 4'd3, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL carry_12: got %h expected %h", obs, exp_v);
    end
    rem = 103;
    while (rem > 0) begin
      n = (rem > 15) ? 15 : rem;
      pulses(n, 1, 0); frame();
      rem -= n;
    end
    exp_v = {8'h99, 4'd3, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL saturate_99: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_lose_lives();
    step(0, 0, 1, 0);
    pulses(3, 0, 1);
    step(0, 0, 0, 1);
    exp_v = {8'h00, 4'd3, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL before_loss: got %h expected %h", obs, exp_v);
    end
    step(0, 0, 0, 1);
    exp_v = {8'h00, 4'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL game_over_rise: got %h expected %h", obs, exp_v);
    end
    frame();
    pulses(4, 1, 1);
    frame();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL over_ignores_events: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_point_during_drain();
    step(0, 0, 1, 0);
    pulses(5, 1, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    frame();
    exp_v = {8'h06, 4'd3, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL point_in_drain: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_new_game_mid_drain();
    step(0, 0, 1, 0);
    pulses(10, 1, 0);
    pulses(2, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    exp_v = {8'h00, 4'd3, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL new_game_mid_drain: got %h expected %h", obs, exp_v);
    end
    frame(); frame();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL pending_cleared: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_extra_life();
    step(0, 0, 1, 0);
    pulses(1, 0, 1);
    pulses(15, 1, 0); frame();
    pulses(15, 1, 0); frame();
    pulses(15, 1, 0); frame();
    pulses(3, 1, 0); frame();
    exp_v = {8'h48, 4'd2, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL setup_48: got %h expected %h", obs, exp_v);
    end
    pulses(3, 1, 0); frame();
`ifdef SCORE_EXTRA_LIFE_EN
    exp_v = {8'h51, 4'd3, 1'b0};
`else
    exp_v = {8'h51, 4'd2, 1'b0};
`endif
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL cross_50: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    bit p, l, ng, vs;
    step(0, 0, 1, 0);
    for (int c = 0; c < 4000; c++) begin
      vs = (c % 64) < 20;
      p  = ($urandom % 4) == 0;
      l  = ($urandom % 48) == 0;
      ng = ($urandom % 150) == 0;
      step(p, l, ng, vs);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL random_c%0d: got %h expected %h", c, obs, model_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_commit_on_frame();
    test_carry_saturation();
    test_lose_lives();
    test_point_during_drain();
    test_new_game_mid_drain();
    test_extra_life();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
